// File: rtl/immgen_pkg.sv
// Shared definitions for the pipelined immediate generator: instruction-class
// encoding, output-buffer sizing and the buffer occupancy update helper.
package immgen_pkg;

  // Instruction classes presented on instType alongside each instruction word.
  typedef enum logic [3:0] {
    IT_LOAD  = 4'd0,
    IT_IMM   = 4'd1,
    IT_STORE = 4'd2,
    IT_REG   = 4'd3,
    IT_LUI   = 4'd4,
    IT_AUIPC = 4'd5,
    IT_BRNCH = 4'd6,
    IT_JALR  = 4'd7,
    IT_JAL   = 4'd8,
    IT_CSR   = 4'd9
  } inst_type_e;

  // Output buffer: two entries, indexed by one-bit pointers.
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W     = 1;

  // Occupancy after one cycle with the given accept/pop outcome.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             acc,
                                                input logic             pop);
    logic [CNT_W-1:0] res;
    case ({acc, pop})
      2'b10:   res = cnt + CNT_W'(1'b1);
      2'b01:   res = cnt - CNT_W'(1'b1);
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/immgen_decode.sv
// Combinational immediate decoder: instruction word + class -> sign-extended
// immediate and an unsupported-class flag. Class 9 (csr, zero-extended zimm)
// is only legal when IMMGEN_CSR_EN is defined.
module immgen_decode
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [3:0]      inst_type,
  output logic [XLEN-1:0] immed,
  output logic            bad_type
);

  logic [31:0] imm32;
  logic        sext;
  logic        unused_opcode;

  // The opcode field carries no immediate bits.
  assign unused_opcode = ^inst[6:0];

  // Assemble the 32-bit immediate for each class.
  always_comb begin
    imm32    = 32'd0;
    bad_type = 1'b0;
    sext     = 1'b1;
    case (inst_type)
      IT_LOAD, IT_IMM, IT_JALR:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      IT_STORE:
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IT_BRNCH:
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IT_JAL:
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IT_LUI, IT_AUIPC:
        imm32 = {inst[31:12], 12'd0};
      IT_REG:
        imm32 = 32'd0;
`ifdef IMMGEN_CSR_EN
      IT_CSR: begin
        imm32 = {27'd0, inst[19:15]};
        sext  = 1'b0;
      end
`else
      IT_CSR: begin
        imm32    = 32'd0;
        bad_type = 1'b1;
      end
`endif
      default: begin
        imm32    = 32'd0;
        bad_type = 1'b1;
      end
    endcase
  end

  // Widen to XLEN; every class except csr extends from bit 31.
  always_comb begin
    immed       = {XLEN{sext & imm32[31]}};
    immed[31:0] = imm32;
  end

endmodule

// File: rtl/immed_gen_pipe.sv
// Pipelined immediate generator: decodes one instruction per cycle into a
// 2-entry output FIFO with valid/ready on both sides and a single-cycle flush.
// Optional feature macro: IMMGEN_CSR_EN (enables csr zimm decode, class 9).
module immed_gen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [31:0]      inst,
  input  logic [3:0]       instType,
  input  logic [TAG_W-1:0] inTag,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [XLEN-1:0]  immed,
  output logic [3:0]       outType,
  output logic [TAG_W-1:0] outTag,
  output logic             badType
);

  typedef struct packed {
    logic [XLEN-1:0]  immed;
    logic [3:0]       typ;
    logic [TAG_W-1:0] tag;
    logic             bad;
  } entry_t;

  entry_t           mem [BUF_DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  dec_immed;
  logic             dec_bad;
  logic             accept;
  logic             pop;

  immgen_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inst     (inst),
    .inst_type(instType),
    .immed    (dec_immed),
    .bad_type (dec_bad)
  );

  // Handshake status comes from registered occupancy only, so inReady never
  // depends on outReady in the same cycle.
  assign inReady  = (count < CNT_W'(BUF_DEPTH));
  assign outValid = (count != {CNT_W{1'b0}});
  assign accept   = inValid & inReady & ~flush;
  assign pop      = outValid & outReady & ~flush;

  assign wr_entry = '{immed: dec_immed, typ: instType, tag: inTag, bad: dec_bad};

  // Result fields are read straight from the head register entry.
  assign head     = mem[rd_ptr];
  assign immed    = head.immed;
  assign outType  = head.typ;
  assign outTag   = head.tag;
  assign badType  = head.bad;

  // Buffer storage: capture the decoded beat into the tail slot on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer ahead of any
  // accept or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1'b1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1'b1);
      end
      count <= cnt_next(count, accept, pop);
    end
  end

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Self-checking bench for immed_gen_pipe: XLEN=32 and XLEN=64 instances share
// one stimulus stream and are compared every cycle against a queue-based model.
module tb_immed_gen_pipe;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [31:0]      inst = 32'd0;
  logic [3:0]       inst_type = 4'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;

  logic             r32_in_ready, r32_out_valid, r32_bad;
  logic [31:0]      r32_immed;
  logic [3:0]       r32_type;
  logic [TAG_W-1:0] r32_tag;
  logic             r64_in_ready, r64_out_valid, r64_bad;
  logic [63:0]      r64_immed;
  logic [3:0]       r64_type;
  logic [TAG_W-1:0] r64_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]      imm;
    logic [3:0]       typ;
    logic [TAG_W-1:0] tag;
    logic             bad;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  immed_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst(rst), .inValid(in_valid), .inReady(r32_in_ready),
    .inst(inst), .instType(inst_type), .inTag(in_tag), .flush(flush),
    .outValid(r32_out_valid), .outReady(out_ready), .immed(r32_immed),
    .outType(r32_type), .outTag(r32_tag), .badType(r32_bad)
  );

  immed_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst(rst), .inValid(in_valid), .inReady(r64_in_ready),
    .inst(inst), .instType(inst_type), .inTag(in_tag), .flush(flush),
    .outValid(r64_out_valid), .outReady(out_ready), .immed(r64_immed),
    .outType(r64_type), .outTag(r64_tag), .badType(r64_bad)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference immediate as a signed integer value, per instruction class.
  function automatic void ref_dec(input logic [31:0] i, input logic [3:0] t,
                                  output logic [63:0] imm, output logic bad);
    longint v;
    bad = 1'b0;
    case (t)
      4'd0, 4'd1, 4'd7: v = longint'($signed(i[31:20]));
      4'd2: v = longint'($signed({i[31:25], i[11:7]}));
      4'd6: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      4'd8: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      4'd4, 4'd5: v = longint'($signed(i[31:12])) * 64'sd4096;
      4'd3: v = 64'sd0;
`ifdef IMMGEN_CSR_EN
      4'd9: v = longint'(i[19:15]);
`endif
      default: begin v = 64'sd0; bad = 1'b1; end
    endcase
    imm = v;
  endfunction

  // Model update on each active edge from the inputs as the DUT saw them.
  always @(posedge clk) begin
    exp_t e;
    bit   acc;
    bit   pp;
    if (rst) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2) && !flush;
      pp  = (q.size() > 0) && out_ready && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          ref_dec(inst, inst_type, e.imm, e.bad);
          e.typ = inst_type;
          e.tag = in_tag;
          q.push_back(e);
        end
      end
    end
  end

  // Compare both instances against the model mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("outValid32", r32_out_valid, q.size() != 0);
      chk("outValid64", r64_out_valid, q.size() != 0);
      chk("inReady32", r32_in_ready, q.size() < 2);
      chk("inReady64", r64_in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("immed32", r32_immed, q[0].imm[31:0]);
        chk("immed64", r64_immed, q[0].imm);
        chk("outType32", r32_type, q[0].typ);
        chk("outType64", r64_type, q[0].typ);
        chk("outTag32", r32_tag, q[0].tag);
        chk("outTag64", r64_tag, q[0].tag);
        chk("badType32", r32_bad, q[0].bad);
        chk("badType64", r64_bad, q[0].bad);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [3:0] t,
                       input logic [TAG_W-1:0] g);
    in_valid  = v;
    inst      = i;
    inst_type = t;
    in_tag    = g;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [31:0] i, input logic [3:0] t, input logic [TAG_W-1:0] g);
    logic r;
    bit   done;
    done = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, i, t, g);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      r = r32_in_ready;
      @(posedge clk);
      if (r) done = 1'b1;
    end
    #1;
    drive(1'b0, 32'd0, 4'd0, '0);
    chk("send_accepted", done, 1'b1);
  endtask

  // Single beat into an empty buffer with outReady high, literal expectation.
  task automatic single(input string name, input logic [31:0] i, input logic [3:0] t,
                        input logic [TAG_W-1:0] g, input logic [63:0] e_imm, input logic e_bad);
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, i, t, g);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 4'd0, '0);
    @(negedge clk);
    chk({name, "_valid"}, r32_out_valid, 1'b1);
    chk({name, "_imm64"}, r64_immed, e_imm);
    chk({name, "_imm32"}, r32_immed, e_imm[31:0]);
    chk({name, "_bad64"}, r64_bad, e_bad);
    chk({name, "_bad32"}, r32_bad, e_bad);
    chk({name, "_tag"}, r32_tag, g);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bb_inst [6];
    logic [3:0]  bb_typ  [6];
    logic [63:0] bb_exp  [6];
    int          t;

    bb_inst = '{32'h038031ef, 32'h08418063, 32'h08320023, 32'h08020183, 32'h003100b3, 32'h07b20193};
    bb_typ  = '{4'd8, 4'd6, 4'd2, 4'd0, 4'd3, 4'd1};
    bb_exp  = '{64'd12344, 64'd128, 64'd128, 64'd128, 64'd0, 64'd123};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outValid", r32_out_valid, 1'b0);
    chk("rst_inReady", r32_in_ready, 1'b1);
    chk("rst_immed64", r64_immed, 64'd0);
    chk("rst_immed32", r32_immed, 32'd0);
    chk("rst_outType", r32_type, 4'd0);
    chk("rst_outTag", r32_tag, '0);
    chk("rst_badType", r32_bad, 1'b0);
    #2 rst = 1'b0;

    // Directed single beats
    single("lui", 32'h030391b7, 4'd4, 5'd1, 64'h0000_0000_0303_9000, 1'b0);
    single("addi_m1", 32'hfff00093, 4'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`ifdef IMMGEN_CSR_EN
    single("csr", 32'h000f9073, 4'd9, 5'd3, 64'd31, 1'b0);
`else
    single("csr", 32'h000f9073, 4'd9, 5'd3, 64'd0, 1'b1);
`endif
    single("type15", 32'h12345678, 4'd15, 5'd4, 64'd0, 1'b1);

    // Back-to-back, one beat per cycle, no bubbles
    out_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k < 6) drive(1'b1, bb_inst[k], bb_typ[k], TAG_W'(8 + k));
      else       drive(1'b0, 32'd0, 4'd0, '0);
      @(negedge clk);
      if (k > 0) begin
        chk("b2b_valid", r32_out_valid, 1'b1);
        chk("b2b_imm64", r64_immed, bb_exp[k-1]);
        chk("b2b_tag", r32_tag, TAG_W'(7 + k));
      end
    end

    // Back-pressure: third beat held off until space reopens
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_beat(32'h00100093, 4'd1, 5'd20);
    send_beat(32'h00200093, 4'd1, 5'd21);
    @(negedge clk);
    chk("bp_full_inReady", r32_in_ready, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h00300093, 4'd1, 5'd22);
    repeat (2) begin
      @(negedge clk);
      chk("bp_held_off", r32_in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_tag_a", r32_tag, 5'd20);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_tag_b", r32_tag, 5'd21);
    chk("bp_reopen", r32_in_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 4'd0, '0);
    @(negedge clk);
    chk("bp_tag_c", r32_tag, 5'd22);
    chk("bp_imm_c", r64_immed, 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", r32_out_valid, 1'b0);

    // Flush with a full buffer and a beat presented
    out_ready = 1'b0;
    send_beat(32'h00a00093, 4'd1, 5'd30);
    send_beat(32'h00b00093, 4'd1, 5'd31);
    @(posedge clk); #1;
    drive(1'b1, 32'h00c00093, 4'd1, 5'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, 32'd0, 4'd0, '0);
    @(negedge clk);
    chk("flush_full_valid", r32_out_valid, 1'b0);
    chk("flush_full_ready", r32_in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_full_gone", r64_out_valid, 1'b0);
    end

    // Flush with one buffered beat while inReady is high
    out_ready = 1'b0;
    send_beat(32'h00d00093, 4'd1, 5'd0);
    @(posedge clk); #1;
    drive(1'b1, 32'h00e00093, 4'd1, 5'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, 32'd0, 4'd0, '0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_one_gone", r32_out_valid, 1'b0);
    end

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send_beat(32'hfff00093, 4'd1, 5'd9);
    send_beat(32'h030391b7, 4'd4, 5'd10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", r32_out_valid, 1'b0);
    chk("arst_ready", r64_in_ready, 1'b1);
    chk("arst_immed", r64_immed, 64'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    // Randomised traffic with back-pressure and occasional flush
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      t = int'($urandom_range(0, 11));
      drive($urandom_range(0, 3) != 0, $urandom, (t == 11) ? 4'd15 : 4'(t), TAG_W'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 4'd0, '0);
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_empty", r32_out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
